// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM between requesters A and B,
// with a bounded burst lock and a fixed one-cycle read-response path back to the winner.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  sram_ce,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_write,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int            CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic          SIDE_A   = 1'b0;
    localparam logic          SIDE_B   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t          state_r;
    logic            last_r;
    logic [CW-1:0]   cnt_r;
    logic            a_rvalid_r;
    logic            b_rvalid_r;

    logic            grant_a_s;
    logic            grant_b_s;
    logic [CW-1:0]   cnt_next_s;

    // Grant decision for this cycle; reset suppresses every grant.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (i_rst) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (a_valid && b_valid) begin
                        grant_a_s = (last_r == SIDE_B);
                        grant_b_s = (last_r == SIDE_A);
                    end else begin
                        grant_a_s = a_valid;
                        grant_b_s = b_valid;
                    end
                end
                OWN_A: begin
                    if (a_valid && ((cnt_r < CNT_MAX) || !b_valid)) begin
                        grant_a_s = 1'b1;
                    end else if (b_valid) begin
                        grant_b_s = 1'b1;
                    end else begin
                        grant_a_s = 1'b0;
                        grant_b_s = 1'b0;
                    end
                end
                OWN_B: begin
                    if (b_valid && ((cnt_r < CNT_MAX) || !a_valid)) begin
                        grant_b_s = 1'b1;
                    end else if (a_valid) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_a_s = 1'b0;
                        grant_b_s = 1'b0;
                    end
                end
                default: begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
            endcase
        end
    end

    // Saturating burst counter increment for a continued grant to the same owner.
    always_comb begin
        cnt_next_s = CNT_MAX;
        if (cnt_r < CNT_MAX) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = CNT_MAX;
        end
    end

    // SRAM request mux: the granted side drives the port, otherwise everything is held at zero.
    always_comb begin
        sram_ce    = grant_a_s | grant_b_s;
        sram_addr  = {ADDR_WIDTH{1'b0}};
        sram_write = 1'b0;
        sram_wdata = {DATA_WIDTH{1'b0}};
        if (grant_a_s) begin
            sram_addr  = a_addr;
            sram_write = a_write;
            sram_wdata = a_wdata;
        end else if (grant_b_s) begin
            sram_addr  = b_addr;
            sram_write = b_write;
            sram_wdata = b_wdata;
        end else begin
            sram_addr  = {ADDR_WIDTH{1'b0}};
            sram_write = 1'b0;
            sram_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Ownership FSM, burst counter, last-owner bit and read-response flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            last_r     <= SIDE_B;
            cnt_r      <= CNT_ZERO;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rvalid_r <= grant_a_s && !a_write;
            b_rvalid_r <= grant_b_s && !b_write;
            if (grant_a_s) begin
                state_r <= OWN_A;
                cnt_r   <= (state_r == OWN_A) ? cnt_next_s : CNT_ONE;
            end else if (grant_b_s) begin
                state_r <= OWN_B;
                cnt_r   <= (state_r == OWN_B) ? cnt_next_s : CNT_ONE;
            end else begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
                case (state_r)
                    OWN_A:   last_r <= SIDE_A;
                    OWN_B:   last_r <= SIDE_B;
                    default: last_r <= last_r;
                endcase
            end
        end
    end

    // A response still in flight when reset rises is dropped, not delivered.
    assign a_rvalid = a_rvalid_r & ~i_rst;
    assign b_rvalid = b_rvalid_r & ~i_rst;
    assign a_rdata  = sram_rdata;
    assign b_rdata  = sram_rdata;
    assign a_ready  = grant_a_s;
    assign b_ready  = grant_b_s;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked every cycle against
// a reference model of the arbitration rules and an ideal memory array.
module tb_sram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          a_valid, a_ready, a_write, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_write, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          sram_ce, sram_write;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [DW-1:0] sram_mem [0:255];

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_write(sram_write),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Single-port BRAM with registered read.
    always @(posedge i_clk) begin
        if (sram_ce) begin
            if (sram_write) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference model: owner 0=none 1=A 2=B, burst count, last owner, expected response.
    int            owner, cnt, last, exp_resp;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] ref_mem [0:255];
    int            seen;
    logic          s_arv, s_brv;
    logic [DW-1:0] s_ard, s_brd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input bit av, input bit bv);
        bit xv, yv;
        if (owner == 0) begin
            if (av && bv) return (last == 2) ? 1 : 2;
            if (av) return 1;
            if (bv) return 2;
            return 0;
        end
        xv = (owner == 1) ? av : bv;
        yv = (owner == 1) ? bv : av;
        if (xv && (cnt < MB || !yv)) return owner;
        if (yv) return 3 - owner;
        return 0;
    endfunction

    // One clock: called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle(input string tag);
        int            g, new_resp;
        bit            wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        #4;
        g = i_rst ? 0 : model_grant(a_valid, b_valid);
        seen  = a_ready ? 1 : (b_ready ? 2 : 0);
        s_arv = a_rvalid; s_brv = b_rvalid; s_ard = a_rdata; s_brd = b_rdata;
        check({tag, ".a_ready"}, a_ready, g == 1);
        check({tag, ".b_ready"}, b_ready, g == 2);
        check({tag, ".sram_ce"}, sram_ce, g != 0);
        wr = (g == 1) ? a_write : b_write;
        ad = (g == 1) ? a_addr  : b_addr;
        wd = (g == 1) ? a_wdata : b_wdata;
        if (g != 0) begin
            check({tag, ".addr"}, sram_addr, ad);
            check({tag, ".write"}, sram_write, wr);
            if (wr) check({tag, ".wdata"}, sram_wdata, wd);
        end
        check({tag, ".a_rvalid"}, a_rvalid, !i_rst && exp_resp == 1);
        check({tag, ".b_rvalid"}, b_rvalid, !i_rst && exp_resp == 2);
        if (!i_rst && exp_resp == 1) check({tag, ".a_rdata"}, a_rdata, exp_data);
        if (!i_rst && exp_resp == 2) check({tag, ".b_rdata"}, b_rdata, exp_data);
        @(posedge i_clk);
        new_resp = 0;
        if (g != 0) begin
            if (wr) ref_mem[ad] = wd;
            else begin new_resp = g; exp_data = ref_mem[ad]; end
        end
        if (i_rst) begin
            owner = 0; last = 2; cnt = 0; new_resp = 0;
        end else if (g == 0) begin
            if (owner != 0) last = owner;
            owner = 0; cnt = 0;
        end else begin
            cnt = (g == owner) ? ((cnt < MB) ? cnt + 1 : MB) : 1;
            owner = g;
        end
        exp_resp = new_resp;
        #1;
    endtask

    task automatic set_a(input bit v, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid = v; a_write = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input bit v, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_valid = v; b_write = w; b_addr = ad; b_wdata = d;
    endtask

    task automatic wait_acc(input int side, input string tag);
        bit done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            cycle(tag);
            done = (seen == side);
        end
        if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic random_phase(input int pa, input int pb, input int n, input int prst);
        for (int i = 0; i < n; i++) begin
            i_rst = ($urandom_range(99) < prst);
            if (!a_valid || seen == 1)
                set_a($urandom_range(99) < pa, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
            if (!b_valid || seen == 2)
                set_b($urandom_range(99) < pb, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
            cycle("rnd");
        end
    endtask

    logic [11:0] pat_a, pat_b;
    int          nb;

    initial begin
        for (int i = 0; i < 256; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        owner = 0; cnt = 0; last = 2; exp_resp = 0; exp_data = '0; seen = 0;
        i_rst = 1'b1;
        set_a(0, 0, 8'h00, 8'h00);
        set_b(0, 0, 8'h00, 8'h00);
        @(posedge i_clk); #1;
        cycle("rst");
        set_a(1, 0, 8'h03, 8'h00); set_b(1, 0, 8'h04, 8'h00);
        cycle("rst_valid");
        i_rst = 1'b0;
        set_a(0, 0, 8'h00, 8'h00); set_b(0, 0, 8'h00, 8'h00);
        cycle("idle0"); cycle("idle1");

        // Both sides continuously valid from the first tie.
        pat_a = '0; pat_b = '0;
        set_a(1, 0, 8'h01, 8'h00); set_b(1, 0, 8'h02, 8'h00);
        for (int i = 0; i < 12; i++) begin
            if (seen == 1 && i > 0) set_a(1, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
            if (seen == 2 && i > 0) set_b(1, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
            cycle("both");
            pat_a[11-i] = (seen == 1);
            pat_b[11-i] = (seen == 2);
        end
        check("burst_pat_a", pat_a, 12'b111100001111);
        check("burst_pat_b", pat_b, 12'b000011110000);

        // Write then read back on A.
        set_b(0, 0, 8'h00, 8'h00);
        set_a(1, 1, 8'h10, 8'h5A); wait_acc(1, "wr10");
        set_a(1, 0, 8'h10, 8'h00); wait_acc(1, "rd10");
        set_a(0, 0, 8'h00, 8'h00);
        cycle("rd10_resp");
        check("rd10_rvalid", s_arv, 1'b1);
        check("rd10_rdata", s_ard, 8'h5A);
        check("rd10_b_rvalid", s_brv, 1'b0);

        // Only B valid: no forced switch, then A wins as soon as it asks.
        nb = 0;
        set_b(1, 0, 8'h05, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cycle("b_only");
            if (seen == 2) nb++;
            set_b(1, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
        end
        check("b_only_grants", nb, 10);
        set_a(1, 0, 8'h06, 8'h00);
        cycle("a_raise");
        check("a_after_b", seen, 1);
        set_a(0, 0, 8'h00, 8'h00); set_b(0, 0, 8'h00, 8'h00);
        cycle("idle2");

        // Interleaved reads routed to the right side.
        set_a(1, 1, 8'h01, 8'h11); wait_acc(1, "wr01"); set_a(0, 0, 8'h00, 8'h00);
        set_b(1, 1, 8'h02, 8'h22); wait_acc(2, "wr02"); set_b(0, 0, 8'h00, 8'h00);
        set_a(1, 0, 8'h01, 8'h00); wait_acc(1, "rd01"); set_a(0, 0, 8'h00, 8'h00);
        set_b(1, 0, 8'h02, 8'h00); wait_acc(2, "rd02");
        check("il_a_rvalid", s_arv, 1'b1);
        check("il_a_rdata", s_ard, 8'h11);
        check("il_b_quiet", s_brv, 1'b0);
        set_b(0, 0, 8'h00, 8'h00);
        cycle("rd02_resp");
        check("il_b_rvalid", s_brv, 1'b1);
        check("il_b_rdata", s_brd, 8'h22);
        check("il_a_quiet", s_arv, 1'b0);

        // Reset right after a read accept drops the response and restores A's tie priority.
        set_b(1, 0, 8'h07, 8'h00); wait_acc(2, "pre_rst"); set_b(0, 0, 8'h00, 8'h00);
        cycle("pre_rst_idle");
        set_a(1, 0, 8'h10, 8'h00); wait_acc(1, "rd_rst");
        set_a(0, 0, 8'h00, 8'h00);
        i_rst = 1'b1;
        cycle("rst_inflight");
        check("rst_drop_rvalid", s_arv, 1'b0);
        cycle("rst_hold");
        i_rst = 1'b0;
        cycle("post_rst");
        check("post_rst_rvalid", s_arv, 1'b0);
        set_a(1, 0, 8'h01, 8'h00); set_b(1, 0, 8'h02, 8'h00);
        cycle("tie_after_rst");
        check("tie_after_rst_grant", seen, 1);

        random_phase(50, 50, 300, 0);
        random_phase(95, 95, 300, 0);
        random_phase(20, 80, 300, 2);
        i_rst = 1'b0;
        random_phase(70, 30, 200, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
